fsm_word_scanner: RTL and testbench

Sequential front end for the 4-state, 1-input, 1-output Mealy machine. It accepts a parallel word on a val/rdy input stream and serializes it LSB-first, one bit per cycle, into a registered instance of the machine. It counts the cycles in which the Mealy output is 1 and returns that count and the final machine state on a val/rdy output stream. It sits between the word-level producer and downstream result consumers.

---
 rtl/fsm_word_scanner_pkg.sv | 17 +
 rtl/fsm_word_scanner_shreg.sv | 27 ++
 rtl/fsm_word_scanner.sv | 112 +++++++++++
 tb/tb_fsm_word_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_word_scanner_pkg.sv
// rtl/fsm_word_scanner_pkg.sv - machine and control state types for fsm_word_scanner
package fsm_word_scanner_pkg;

    typedef enum logic [1:0] {
        M_A = 2'd0,
        M_B = 2'd1,
        M_C = 2'd2,
        M_D = 2'd3
    } mstate_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_SCAN = 2'd1,
        C_DONE = 2'd2
    } cstate_t;

endpackage

// File: rtl/fsm_word_scanner_shreg.sv
// rtl/fsm_word_scanner_shreg.sv - load/shift-right register exposing bit 0
module fsm_word_scanner_shreg #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [NBITS-1:0] din,
    output logic             bit0
);

    logic [NBITS-1:0] data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= data >> 1;
        end
    end

    assign bit0 = data[0];

endmodule

// File: rtl/fsm_word_scanner.sv
// rtl/fsm_word_scanner.sv - serializes a word LSB-first through a 4-state Mealy machine, counts 1-outputs
// Optional: FSM_WORD_SCANNER_STATE_CARRY_EN keeps the machine state across words.
module fsm_word_scanner
    import fsm_word_scanner_pkg::*;
#(
    parameter int NBITS = 8,
    localparam int CW = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] istream_msg,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [CW-1:0]    ostream_count,
    output logic [1:0]       ostream_state
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    cstate_t       cstate, cstate_next;
    mstate_t       mstate, m_next;
    logic          m_out;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    logic          load, shift, bit0;

    fsm_word_scanner_shreg #(.NBITS(NBITS)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (istream_msg),
        .bit0  (bit0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cstate <= C_IDLE;
        end else begin
            cstate <= cstate_next;
        end
    end

    always_comb begin
        cstate_next = cstate;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        case (cstate)
            C_IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    load        = 1'b1;
                    cstate_next = C_SCAN;
                end
            end
            C_SCAN: begin
                shift = 1'b1;
                if (idx == LAST_IDX) begin
                    cstate_next = C_DONE;
                end
            end
            C_DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    cstate_next = C_IDLE;
                end
            end
            default: cstate_next = C_IDLE;
        endcase
    end

    // Mealy transition/output for the bit currently at the head of the shift register
    always_comb begin
        m_next = mstate;
        m_out  = 1'b0;
        case (mstate)
            M_A: begin m_next = bit0 ? M_B : M_A; m_out = bit0;  end
            M_B: begin m_next = bit0 ? M_B : M_C; m_out = ~bit0; end
            M_C: begin m_next = bit0 ? M_D : M_A; m_out = bit0;  end
            M_D: begin m_next = bit0 ? M_B : M_C; m_out = 1'b0;  end
            default: begin m_next = M_A; m_out = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstate <= M_A;
            count  <= '0;
            idx    <= '0;
        end else if (load) begin
            count <= '0;
            idx   <= '0;
`ifdef FSM_WORD_SCANNER_STATE_CARRY_EN
            mstate <= mstate;
`else
            mstate <= M_A;
`endif
        end else if (shift) begin
            mstate <= m_next;
            count  <= count + CW'(m_out);
            idx    <= idx + CW'(1);
        end
    end

    assign ostream_count = count;
    assign ostream_state = mstate;

endmodule

// File: tb/tb_fsm_word_scanner.sv
// tb/tb_fsm_word_scanner.sv - directed and randomized self-checking bench for fsm_word_scanner
module tb_fsm_word_scanner;

    localparam int NBITS = 8;
    localparam int CW = $clog2(NBITS + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             istream_val = 1'b0;
    logic             istream_rdy;
    logic [NBITS-1:0] istream_msg = '0;
    logic             ostream_val;
    logic             ostream_rdy = 1'b0;
    logic [CW-1:0]    ostream_count;
    logic [1:0]       ostream_state;

    int n_cmp = 0;
    int n_err = 0;
    int model_state = 0;

    // Transition and output tables indexed [state][input]
    int nt [0:3][0:1] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
    int ot [0:3][0:1] = '{'{0, 1}, '{1, 0}, '{0, 1}, '{0, 0}};

    fsm_word_scanner #(.NBITS(NBITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .istream_val   (istream_val),
        .istream_rdy   (istream_rdy),
        .istream_msg   (istream_msg),
        .ostream_val   (ostream_val),
        .ostream_rdy   (ostream_rdy),
        .ostream_count (ostream_count),
        .ostream_state (ostream_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [NBITS-1:0] w, input int s0,
                                  output int cnt, output int sf);
        int s;
        int b;
        s = s0;
        cnt = 0;
        for (int i = 0; i < NBITS; i++) begin
            b = (w >> i) & 1;
            cnt += ot[s][b];
            s = nt[s][b];
        end
        sf = s;
    endfunction

    function automatic int start_state();
`ifdef FSM_WORD_SCANNER_STATE_CARRY_EN
        return model_state;
`else
        return 0;
`endif
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (istream_rdy !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_wait", int'(istream_rdy), 1);
    endtask

    // Accept a word, check latency, hold for `hold` cycles in DONE, then drain
    task automatic run_word(input logic [NBITS-1:0] w, input int hold, input int gap,
                            output int got_cnt, output int got_st);
        int ec, es;
        model(w, start_state(), ec, es);
        wait_idle();
        repeat (gap) begin @(posedge clk); #1; end
        istream_val = 1'b1;
        istream_msg = w;
        @(posedge clk); #1;
        istream_val = 1'b0;
        istream_msg = NBITS'($urandom);
        check("scan_rdy_low", int'(istream_rdy), 0);
        repeat (NBITS - 1) @(posedge clk);
        #1;
        check("val_not_early", int'(ostream_val), 0);
        @(posedge clk); #1;
        check("val_on_time", int'(ostream_val), 1);
        check("count", int'(ostream_count), ec);
        check("state", int'(ostream_state), es);
        for (int h = 0; h < hold; h++) begin
            istream_val = 1'b1;
            @(posedge clk); #1;
            istream_val = 1'b0;
            check("hold_val", int'(ostream_val), 1);
            check("hold_rdy", int'(istream_rdy), 0);
            check("hold_count", int'(ostream_count), ec);
            check("hold_state", int'(ostream_state), es);
        end
        got_cnt = int'(ostream_count);
        got_st = int'(ostream_state);
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
        check("drain_val", int'(ostream_val), 0);
        check("drain_rdy", int'(istream_rdy), 1);
        model_state = es;
    endtask

    initial begin
        int c, s;
        logic [NBITS-1:0] w;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", int'(istream_rdy), 1);
        check("rst_val", int'(ostream_val), 0);
        check("rst_count", int'(ostream_count), 0);
        check("rst_state", int'(ostream_state), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_word(8'h00, 0, 0, c, s);
        check("w00_count", c, 0);
        check("w00_state", s, 0);

        run_word(8'hFF, 0, 0, c, s);
`ifndef FSM_WORD_SCANNER_STATE_CARRY_EN
        check("wFF_count", c, 1);
        check("wFF_state", s, 1);
`endif

        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_state = 0;
        @(posedge clk); #1;
        run_word(8'h55, 0, 0, c, s);
        check("w55_count", c, 5);
        check("w55_state", s, 2);
        run_word(8'h01, 0, 0, c, s);
`ifdef FSM_WORD_SCANNER_STATE_CARRY_EN
        check("w01_count", c, 1);
`else
        check("w01_count", c, 2);
`endif
        check("w01_state", s, 0);

        run_word(NBITS'($urandom), 3, 0, c, s);

        // Reset during the 4th SCAN cycle discards the word
        wait_idle();
        istream_val = 1'b1;
        istream_msg = 8'hA5;
        @(posedge clk); #1;
        istream_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_rdy", int'(istream_rdy), 1);
        check("midrst_val", int'(ostream_val), 0);
        check("midrst_count", int'(ostream_count), 0);
        check("midrst_state", int'(ostream_state), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_state = 0;
        check("postrst_rdy", int'(istream_rdy), 1);
        check("postrst_val", int'(ostream_val), 0);
        run_word(8'hFF, 0, 0, c, s);
        check("postrst_FF_count", c, 1);
        check("postrst_FF_state", s, 1);

        for (int i = 0; i < 30; i++) begin
            w = NBITS'($urandom);
            run_word(w, $urandom_range(0, 2), $urandom_range(0, 2), c, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
